// File: rtl/instr_rom_pipe.sv
// Pipelined instruction ROM with a valid/ready fetch interface, flush for branch
// redirects, and a full-pipeline stall whenever the head response is not taken.
module instr_rom_pipe #(
  parameter int                DATA_W       = 32,
  parameter int                ADDR_W       = 16,
  parameter int                DEPTH        = 8,
  parameter int                LATENCY      = 2,
  parameter logic [DATA_W-1:0] DEFAULT_WORD = DATA_W'(32'hD60003E0)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  input  logic              flush,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_oob
);

  typedef struct packed {
    logic              valid;
    logic              oob;
    logic [DATA_W-1:0] data;
  } stage_t;

  localparam int ROM_WORDS = 8;
  localparam logic [31:0] ROM_INIT [ROM_WORDS] = '{
    32'hF8400140, 32'hF8400161, 32'h8B050083, 32'hCB050086,
    32'hAA050087, 32'h8A050088, 32'h8B010002, 32'hF8000142
  };
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  // Word lookup; the zero-extended compare keeps DEPTH == 2**ADDR_W legal.
  function automatic stage_t lookup(input logic [ADDR_W-1:0] addr);
    stage_t          s;
    logic [ADDR_W:0] a_ext;
    a_ext  = {1'b0, addr};
    s.valid = 1'b0;
    s.oob   = (a_ext >= DEPTH_C);
    s.data  = DEFAULT_WORD;
    for (int i = 0; i < ROM_WORDS; i++) begin
      if (i < DEPTH && a_ext == (ADDR_W+1)'(i)) s.data = DATA_W'(ROM_INIT[i]);
    end
    return s;
  endfunction

  stage_t pipe [LATENCY];
  stage_t fetch;
  logic   stall;
  logic   advance;

  assign rsp_valid = pipe[LATENCY-1].valid;
  assign stall     = rsp_valid && !rsp_ready;
  assign req_ready = !stall || flush;
  assign advance   = !stall || flush;

  // NOTE: every variable written here gets a full default first, so no latch can form.
  always_comb begin
    fetch       = lookup(req_addr);
    fetch.valid = req_valid && req_ready;
  end

  // NOTE: only the valid bits are reset; payload bits are don't-care while invalid,
  // and sequential state uses non-blocking assignments so stages shift in lockstep.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LATENCY; i++) pipe[i].valid <= 1'b0;
    end else if (advance) begin
      pipe[0] <= fetch;
      for (int i = 1; i < LATENCY; i++) begin
        pipe[i] <= '{valid: pipe[i-1].valid && !flush,
                     oob:   pipe[i-1].oob,
                     data:  pipe[i-1].data};
      end
    end
  end

  // Invalid responses present the default word and a clear oob flag.
  assign rsp_data = rsp_valid ? pipe[LATENCY-1].data : DEFAULT_WORD;
  assign rsp_oob  = rsp_valid && pipe[LATENCY-1].oob;

endmodule

// File: tb/tb_instr_rom_pipe.sv
// Scoreboard bench for instr_rom_pipe: LATENCY=2 takes the full directed run,
// LATENCY=1 and LATENCY=4 share the sequential-fetch phase.
module tb_instr_rom_pipe;

  localparam logic [31:0] DEF = 32'hD60003E0;
  localparam logic [31:0] ROM_EXP [8] = '{
    32'hF8400140, 32'hF8400161, 32'h8B050083, 32'hCB050086,
    32'hAA050087, 32'h8A050088, 32'h8B010002, 32'hF8000142
  };

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic [15:0] req_addr = '0;
  logic        flush = 1'b0;
  logic        rsp_ready = 1'b1;
  logic        side_en = 1'b1;
  logic        side_req_valid;

  logic        req_ready1, rsp_valid1, rsp_oob1;
  logic        req_ready2, rsp_valid2, rsp_oob2;
  logic        req_ready4, rsp_valid4, rsp_oob4;
  logic [31:0] rsp_data1, rsp_data2, rsp_data4;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [32:0] q1 [$];
  logic [32:0] q2 [$];
  logic [32:0] q4 [$];

  assign side_req_valid = req_valid && side_en;

  always #5 clk = ~clk;

  instr_rom_pipe #(.LATENCY(2)) dut2 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready2), .flush(flush), .rsp_valid(rsp_valid2),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data2), .rsp_oob(rsp_oob2)
  );

  instr_rom_pipe #(.LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .req_valid(side_req_valid), .req_addr(req_addr),
    .req_ready(req_ready1), .flush(1'b0), .rsp_valid(rsp_valid1),
    .rsp_ready(1'b1), .rsp_data(rsp_data1), .rsp_oob(rsp_oob1)
  );

  instr_rom_pipe #(.LATENCY(4)) dut4 (
    .clk(clk), .reset(reset), .req_valid(side_req_valid), .req_addr(req_addr),
    .req_ready(req_ready4), .flush(1'b0), .rsp_valid(rsp_valid4),
    .rsp_ready(1'b1), .rsp_data(rsp_data4), .rsp_oob(rsp_oob4)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [32:0] exp_of(input logic [15:0] a);
    return (a < 16'd8) ? {1'b0, ROM_EXP[a[2:0]]} : {1'b1, DEF};
  endfunction

  // Monitors: pop and compare on every handshake.
  always @(negedge clk) begin
    if (reset === 1'b0 && rsp_valid2 && rsp_ready) begin
      if (q2.size() == 0) check("lat2_unexpected_rsp", 64'(rsp_data2), 64'(DEF) + 64'd1);
      else check("lat2_rsp", {rsp_oob2, rsp_data2}, q2.pop_front());
    end
  end

  always @(negedge clk) begin
    if (reset === 1'b0 && rsp_valid1) begin
      if (q1.size() == 0) check("lat1_unexpected_rsp", 64'(rsp_data1), 64'(DEF) + 64'd1);
      else check("lat1_rsp", {rsp_oob1, rsp_data1}, q1.pop_front());
    end
  end

  always @(negedge clk) begin
    if (reset === 1'b0 && rsp_valid4) begin
      if (q4.size() == 0) check("lat4_unexpected_rsp", 64'(rsp_data4), 64'(DEF) + 64'd1);
      else check("lat4_rsp", {rsp_oob4, rsp_data4}, q4.pop_front());
    end
  end

  // Present one request and hold it until accepted; expectation pushed at the accepting edge.
  task automatic issue(input logic [15:0] a, input bit all);
    bit acc;
    int n;
    acc = 1'b0;
    n   = 0;
    req_valid = 1'b1;
    req_addr  = a;
    while (!acc && n < 40) begin
      @(negedge clk);
      acc = req_ready2;
      @(posedge clk);
      n++;
    end
    if (acc) begin
      q2.push_back(exp_of(a));
      if (all) begin
        q1.push_back(exp_of(a));
        q4.push_back(exp_of(a));
      end
    end else begin
      check("issue_accept_timeout", 64'(acc), 64'd1);
    end
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((q1.size() + q2.size() + q4.size()) != 0 && n < 30) begin
      @(posedge clk);
      n++;
    end
    check("drain_outstanding", 64'(q1.size() + q2.size() + q4.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, required finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clk);
    check("reset_rsp_valid", rsp_valid2, 0);
    check("reset_rsp_oob",   rsp_oob2,   0);
    check("reset_rsp_data",  rsp_data2,  DEF);
    check("reset_req_ready", req_ready2, 1);
    check("reset_lat1_data", rsp_data1,  DEF);
    check("reset_lat4_valid", rsp_valid4, 0);
    @(posedge clk);
    #1;

    // Sequential fetch 0..7 on all latencies, first-valid timing checked per cycle
    fork
      begin
        for (int i = 0; i < 8; i++) issue(16'(i), 1'b1);
      end
      begin
        @(posedge clk);
        for (int k = 0; k < 6; k++) begin
          @(negedge clk);
          check("lat1_first_valid", rsp_valid1, 1);
          check("lat2_first_valid", rsp_valid2, k >= 1);
          check("lat4_first_valid", rsp_valid4, k >= 3);
        end
      end
    join
    side_en = 1'b0;
    wait_drain();

    // Out-of-range addresses
    issue(16'd8, 1'b0);
    issue(16'hFFFF, 1'b0);
    wait_drain();

    // Backpressure for three cycles once the first response shows
    fork
      begin
        issue(16'd0, 1'b0);
        issue(16'd1, 1'b0);
        issue(16'd2, 1'b0);
      end
      begin
        int n;
        n = 0;
        do begin
          @(posedge clk);
          #1;
          n++;
        end while (!rsp_valid2 && n < 20);
        rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          check("stall_req_ready", req_ready2, 0);
          check("stall_rsp_valid", rsp_valid2, 1);
          check("stall_hold_data", rsp_data2, 32'hF8400140);
          @(posedge clk);
          #1;
        end
        rsp_ready = 1'b1;
      end
    join
    wait_drain();

    // Flush with 3 and 4 in flight; request 6 rides the flush
    issue(16'd3, 1'b0);
    issue(16'd4, 1'b0);
    rsp_ready = 1'b0;
    flush     = 1'b1;
    req_valid = 1'b1;
    req_addr  = 16'd6;
    @(negedge clk);
    check("flush_req_ready", req_ready2, 1);
    @(posedge clk);
    q2.delete();
    q2.push_back(exp_of(16'd6));
    #1;
    flush     = 1'b0;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("flush_cleared_head", rsp_valid2, 0);
    wait_drain();

    // Reset with two fetches in flight and a request presented
    issue(16'd1, 1'b0);
    issue(16'd2, 1'b0);
    rsp_ready = 1'b0;
    reset     = 1'b1;
    req_valid = 1'b1;
    req_addr  = 16'd5;
    @(posedge clk);
    q2.delete();
    #1;
    reset     = 1'b0;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("post_reset_rsp_valid", rsp_valid2, 0);
      check("post_reset_req_ready", req_ready2, 1);
      check("post_reset_rsp_data",  rsp_data2,  DEF);
      check("post_reset_rsp_oob",   rsp_oob2,   0);
    end
    repeat (4) @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
